// File: rtl/stream_mux_n.sv
// stream_mux_n
// N-input, W-bit stream multiplexer with valid/ready handshakes on every
// input and a single registered output stage. The channel feeding each output
// beat is chosen by an external select (MODE=0) or by round-robin among the
// valid inputs (MODE=1). out_src reports which channel supplied out_data.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   sel        channel select, used only when MODE=0
//   in_data    packed input data, channel i at [i*W +: W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   out_data   registered output data
//   out_valid  registered output valid
//   out_ready  consumer ready
//   out_src    index of the channel that supplied out_data
module stream_mux_n #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int MODE = 0,
  localparam int SW  = (N > 2) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SW-1:0]   sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_src
);

  logic [SW-1:0] ptr_r;
  logic [W-1:0]  out_data_r;
  logic          out_valid_r;
  logic [SW-1:0] out_src_r;

  logic          load_ok_s;
  logic          grant_valid_s;
  logic [SW-1:0] grant_idx_s;
  logic          xfer_s;
  logic [N-1:0]  in_ready_s;

  // The output register may take a new beat when empty or draining this cycle.
  assign load_ok_s = !out_valid_r || out_ready;

  // Grant selection: external select, or first valid channel scanning from ptr.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    if (MODE == 0) begin
      // An out-of-range select (possible when N is not a power of two)
      // never grants.
      if (int'(sel) < N) begin
        if (in_valid[int'(sel)]) begin
          grant_valid_s = 1'b1;
          grant_idx_s   = sel;
        end else begin
          grant_valid_s = 1'b0;
        end
      end else begin
        grant_valid_s = 1'b0;
      end
    end else begin
      // Scan from the far end back towards ptr so the last hit is the
      // first valid channel at or after ptr (modulo N).
      for (int k = N - 1; k >= 0; k--) begin
        if (in_valid[(int'(ptr_r) + k) % N]) begin
          grant_valid_s = 1'b1;
          grant_idx_s   = SW'((int'(ptr_r) + k) % N);
        end else begin
          grant_valid_s = grant_valid_s;
        end
      end
    end
  end

  assign xfer_s = !reset && load_ok_s && grant_valid_s;

  // One-hot ready towards the granted channel only.
  always_comb begin
    in_ready_s = '0;
    if (xfer_s) begin
      in_ready_s[int'(grant_idx_s)] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
  end

  assign in_ready = in_ready_s;

  // Output register: load on input transfer, clear valid on drain, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_src_r   <= '0;
    end else if (xfer_s) begin
      out_data_r  <= in_data[int'(grant_idx_s)*W +: W];
      out_valid_r <= 1'b1;
      out_src_r   <= grant_idx_s;
    end else if (out_ready) begin
      // Data and source are left as-is after a drain; only valid drops.
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Round-robin pointer: advance past the granted channel on each transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
    end else if ((MODE == 1) && xfer_s) begin
      ptr_r <= SW'((int'(grant_idx_s) + 1) % N);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_src   = out_src_r;

endmodule

// File: tb/tb_stream_mux_n.sv
// Testbench for stream_mux_n. Three instances share clk and reset:
//   a: MODE=0, N=4   b: MODE=0, N=3 (out-of-range select)   c: MODE=1, N=4
// A reference model predicts in_ready and pushes expected {src,data} beats
// into a scoreboard queue; beats are compared while the DUT presents them and
// popped when the consumer accepts them.
module tb_stream_mux_n;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic [1:0]  sel_a, sel_b, sel_c;
  logic [3:0]  val_a, val_c, rdy_a, rdy_c;
  logic [2:0]  val_b, rdy_b;
  logic [31:0] dat_a, dat_c;
  logic [23:0] dat_b;
  logic        ordy_a, ordy_b, ordy_c;
  logic [7:0]  od_a, od_b, od_c;
  logic        ov_a, ov_b, ov_c;
  logic [1:0]  os_a, os_b, os_c;

  stream_mux_n #(.W(8), .N(4), .MODE(0)) u_a (
    .clk(clk), .reset(reset), .sel(sel_a), .in_data(dat_a), .in_valid(val_a),
    .in_ready(rdy_a), .out_data(od_a), .out_valid(ov_a), .out_ready(ordy_a),
    .out_src(os_a));

  stream_mux_n #(.W(8), .N(3), .MODE(0)) u_b (
    .clk(clk), .reset(reset), .sel(sel_b), .in_data(dat_b), .in_valid(val_b),
    .in_ready(rdy_b), .out_data(od_b), .out_valid(ov_b), .out_ready(ordy_b),
    .out_src(os_b));

  stream_mux_n #(.W(8), .N(4), .MODE(1)) u_c (
    .clk(clk), .reset(reset), .sel(sel_c), .in_data(dat_c), .in_valid(val_c),
    .in_ready(rdy_c), .out_data(od_c), .out_valid(ov_c), .out_ready(ordy_c),
    .out_src(os_c));

  int checks   = 0;
  int failures = 0;

  logic [9:0] sbq[$];   // expected beats {src[1:0], data[7:0]}
  int         mptr;     // model round-robin pointer

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with inputs for the coming posedge already driven.
  // Checks the active instance against the model, then advances one cycle.
  task automatic step(input int id);
    int          n, mode, g;
    logic [1:0]  s, os;
    logic [3:0]  v, r, er;
    logic [31:0] d;
    logic        o_r, ov, lok, gv;
    logic [7:0]  od;
    #1;
    case (id)
      0: begin n = 4; mode = 0; s = sel_a; v = val_a; d = dat_a; o_r = ordy_a;
               r = rdy_a; ov = ov_a; od = od_a; os = os_a; end
      1: begin n = 3; mode = 0; s = sel_b; v = {1'b0, val_b}; d = {8'h00, dat_b};
               o_r = ordy_b; r = {1'b0, rdy_b}; ov = ov_b; od = od_b; os = os_b; end
      default: begin n = 4; mode = 1; s = sel_c; v = val_c; d = dat_c; o_r = ordy_c;
               r = rdy_c; ov = ov_c; od = od_c; os = os_c; end
    endcase
    chk("out_valid", {31'd0, ov}, {31'd0, (sbq.size() != 0)});
    if (sbq.size() != 0 && ov) begin
      chk("out_data", {24'd0, od}, {24'd0, sbq[0][7:0]});
      chk("out_src", {30'd0, os}, {30'd0, sbq[0][9:8]});
    end
    lok = (sbq.size() == 0) || o_r;
    gv = 1'b0;
    g  = 0;
    if (mode == 0) begin
      if (int'(s) < n && v[s]) begin gv = 1'b1; g = int'(s); end
    end else begin
      for (int k = n - 1; k >= 0; k--) begin
        if (v[(mptr + k) % n]) begin gv = 1'b1; g = (mptr + k) % n; end
      end
    end
    er = 4'd0;
    if (!reset && lok && gv) er[g] = 1'b1;
    chk("in_ready", {28'd0, r}, {28'd0, er});
    if (reset) begin
      sbq.delete();
      mptr = 0;
    end else begin
      if (sbq.size() != 0 && o_r) void'(sbq.pop_front());
      if (lok && gv) begin
        sbq.push_back({2'(g), d[g*8 +: 8]});
        if (mode == 1) mptr = (g + 1) % n;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    sel_a = 2'd0; sel_b = 2'd0; sel_c = 2'd0;
    val_a = 4'hF; val_b = 3'h7; val_c = 4'hF;
    dat_a = 32'h0; dat_b = 24'h0; dat_c = 32'h13121110;
    ordy_a = 1'b1; ordy_b = 1'b1; ordy_c = 1'b1;
    mptr = 0;
    @(negedge clk);

    // Reset held two cycles with every input valid.
    step(2);
    chk("rst_rdy_a", {28'd0, rdy_a}, 32'd0);
    chk("rst_rdy_b", {29'd0, rdy_b}, 32'd0);
    step(2);
    chk("rst_data", {24'd0, od_c}, 32'd0);
    chk("rst_src", {30'd0, os_c}, 32'd0);
    reset = 1'b0;
    val_a = 4'h0; val_b = 3'h0;

    // Round-robin, all valid: 0,1,2,3,0,1,... with no bubbles.
    for (int i = 0; i < 8; i++) step(2);
    val_c = 4'h0;
    step(2);

    // Leave a beat from ch1 (8'h11) in the register, then stall 3 cycles.
    val_c = 4'b0010;
    step(2);
    ordy_c = 1'b0;
    val_c  = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      chk("stall_data", {24'd0, od_c}, 32'h11);
      step(2);
    end
    ordy_c = 1'b1;
    step(2);
    step(2);
    val_c = 4'h0;
    step(2);

    // Reset while a beat is stalled in the register.
    val_c = 4'hF;
    step(2);
    ordy_c = 1'b0;
    val_c  = 4'h0;
    step(2);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    chk("mid_rst_valid", {31'd0, ov_c}, 32'd0);
    chk("mid_rst_data", {24'd0, od_c}, 32'd0);
    ordy_c = 1'b1;
    val_c  = 4'hF;
    step(2);
    val_c = 4'h0;
    step(2);
    step(2);

    // External select, N=4.
    sel_a = 2'd2; val_a = 4'b0100; dat_a = 32'h00A50000; ordy_a = 1'b1;
    step(0);
    sel_a = 2'd3;
    step(0);
    step(0);
    for (int i = 0; i < 24; i++) begin
      sel_a  = 2'($urandom_range(0, 3));
      val_a  = 4'($urandom_range(0, 15));
      dat_a  = $urandom;
      ordy_a = 1'($urandom_range(0, 1));
      step(0);
    end
    val_a = 4'h0; ordy_a = 1'b1;
    step(0);
    step(0);

    // External select, N=3: sel=3 is out of range and never grants.
    sel_b = 2'd3; val_b = 3'h7; dat_b = 24'h332211; ordy_b = 1'b1;
    for (int i = 0; i < 5; i++) step(1);
    sel_b = 2'd1;
    step(1);
    val_b = 3'h0;
    step(1);
    step(1);

    // Round-robin under random valids and backpressure.
    for (int i = 0; i < 40; i++) begin
      val_c  = 4'($urandom_range(0, 15));
      dat_c  = $urandom;
      ordy_c = 1'($urandom_range(0, 1));
      step(2);
    end
    val_c = 4'h0; ordy_c = 1'b1;
    step(2);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised N-input, W-bit stream multiplexer: successor to the team's fixed 8-bit 2:1 combinational mux.
- Adds a valid/ready handshake on every input, a one-stage registered output and two arbitration modes: external select or round-robin.
- Sits between multiple producer channels and a single consumer datapath. Also reports which source each output beat came from.

Parameters:
- W, 8, data width per channel in bits (W >= 1).
- N, 4, number of input channels (N >= 2).
- MODE, 0, arbitration mode: 0 = external select via sel, 1 = round-robin among valid inputs.
- SW (localparam), max(1, clog2(N)), width of the select and source-index fields.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- sel  input  SW  channel select; used only when MODE=0.
- in_data  input  N*W  packed input data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational from state, sel and in_valid.
- out_data  output  W  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_src  output  SW  index of the channel that supplied the current out_data.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset; nothing is sampled asynchronously.
- Reset values: out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0. in_ready is 0 while reset is high.
- Load enable: load_ok = !out_valid || out_ready. This allows full throughput of one beat per cycle with a registered output.
- Grant selection, MODE=0:
  - g = sel. A grant exists only if sel < N and in_valid[sel]=1.
  - sel >= N means no grant: all in_ready=0 and the register is not loaded.
- Grant selection, MODE=1:
  - g = the first i with in_valid[i]=1, scanning ptr, ptr+1, ..., ptr+N-1 modulo N.
  - No valid input means no grant.
- in_ready[i] = load_ok && grant exists && (i == g). At most one bit is set at any time.
- Transfer on an input: in_valid[g] && in_ready[g] at a rising edge. On the next cycle out_data = that channel's data, out_src = g, out_valid = 1.
  - Latency: 1 cycle from input transfer to out_valid.
- Output transfer: out_valid && out_ready.
  - If no input transfer happens in the same cycle, out_valid goes to 0 on the next edge.
  - out_data and out_src hold their last values; no clearing.
- Stall: while out_valid=1 and out_ready=0, out_data, out_src and out_valid hold stable, and every in_ready=0.
- Round-robin pointer: on each input transfer in MODE=1, ptr <= (g+1) mod N. The pointer does not move when there is no transfer. In MODE=0 ptr stays 0.
- Simultaneous output drain and new input transfer: the register reloads in the same edge and out_valid stays 1 (back-to-back beats).
- Wrap-around: with g = N-1, ptr wraps to 0. N need not be a power of two.
- Reset mid-operation: any pending beat in the output register is discarded. The outputs return to their reset values on the edge where reset is sampled high.
- Inputs are not required to hold in_valid while in_ready=0. The block makes no assumption about input stability.

Test Plan:
- Reset: hold reset 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_src=0, in_ready=0 throughout; first grant after release goes to ch0 in MODE=1.
- MODE=0, W=8, N=4: sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_src=2, out_valid=1. Then sel=3 with in_valid[3]=0 -> out_valid drops to 0.
- MODE=0, N=3, sel=3 (out of range), all valid -> in_ready=0 and out_valid remains 0 indefinitely.
- MODE=1, N=4, all in_valid=1, out_ready=1, channel data = 8'h10+i -> out_src sequence 0,1,2,3,0,1 and out_data 10,11,12,13,10,11 on consecutive cycles, with no bubbles.
- Backpressure, MODE=1: out_ready=0 for 3 cycles with out_valid=1, out_data=8'h11 -> out_data, out_src and out_valid stable and in_ready=0. On release, the beat drains and the next beat comes from ptr=2 (skipping invalid channels).
- Reset mid-stall: out_valid=1, out_ready=0, reset pulsed 1 cycle -> out_valid=0, out_data=0; ptr restarts at 0.
